// File: rtl/wand_path_controller.sv
// Tutorial wand path sequencer: walks the wand sprite along a stored spell pattern on the
// 4x4 spell-node grid, one STEP_PX move per tick, and cycles the sprite frame while running.
module wand_path_controller #(
  parameter int unsigned STEP_TICKS  = 10000000,
  parameter int unsigned FRAME_TICKS = 5000,
  parameter int unsigned STEP_PX     = 20,
  parameter int unsigned HOLD_TICKS  = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       learn_mode_i,
  input  logic       start_i,
  input  logic [1:0] spell_sel_i,
  output logic [8:0] wand_row_o,
  output logic [9:0] wand_col_o,
  output logic [3:0] now_node_o,
  output logic [3:0] next_node_o,
  output logic [1:0] frame_sel_o,
  output logic       busy_o,
  output logic       seg_done_o,
  output logic       done_o
);

  localparam int unsigned TickW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned FrameW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned HoldW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TickW-1:0]  TickLast  = TickW'(STEP_TICKS - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(FRAME_TICKS - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic [8:0]        StepRow   = 9'(STEP_PX);
  localparam logic [9:0]        StepCol   = 10'(STEP_PX);

  typedef enum logic [2:0] {StIdle, StHome, StMove, StDwell, StDone} state_e;

  // 100*k built from shifts: 64k + 32k + 4k.
  function automatic logic [8:0] node_row(input logic [3:0] n);
    logic [8:0] k;
    k = {7'd0, n[3:2]};
    return 9'd90 + (k << 6) + (k << 5) + (k << 2);
  endfunction

  function automatic logic [9:0] node_col(input logic [3:0] n);
    logic [9:0] k;
    k = {8'd0, n[1:0]};
    return 10'd170 + (k << 6) + (k << 5) + (k << 2);
  endfunction

  function automatic logic [3:0] spell_node(input logic [1:0] s, input logic [2:0] i);
    logic [3:0] n;
    n = 4'd0;
    case (s)
      2'd0: begin
        case (i)
          3'd0:    n = 4'd5;
          3'd1:    n = 4'd6;
          3'd2:    n = 4'd7;
          3'd3:    n = 4'd11;
          3'd4:    n = 4'd10;
          default: n = 4'd0;
        endcase
      end
      2'd1: begin
        case (i)
          3'd0:    n = 4'd0;
          3'd1:    n = 4'd1;
          3'd2:    n = 4'd2;
          3'd3:    n = 4'd3;
          3'd4:    n = 4'd7;
          3'd5:    n = 4'd11;
          3'd6:    n = 4'd15;
          default: n = 4'd0;
        endcase
      end
      2'd2: begin
        case (i)
          3'd0:    n = 4'd12;
          3'd1:    n = 4'd8;
          3'd2:    n = 4'd4;
          3'd3:    n = 4'd0;
          default: n = 4'd0;
        endcase
      end
      default: begin
        case (i)
          3'd0:    n = 4'd5;
          3'd1:    n = 4'd6;
          3'd2:    n = 4'd5;
          3'd3:    n = 4'd6;
          default: n = 4'd0;
        endcase
      end
    endcase
    return n;
  endfunction

  // Index of the final node of each pattern.
  function automatic logic [2:0] spell_last(input logic [1:0] s);
    logic [2:0] l;
    case (s)
      2'd0:    l = 3'd4;
      2'd1:    l = 3'd6;
      default: l = 3'd3;
    endcase
    return l;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        spell_q, spell_d;
  logic [2:0]        idx_q, idx_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]        frame_sel_q, frame_sel_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [8:0]        row_q, row_d;
  logic [9:0]        col_q, col_d;
  logic [3:0]        now_q, now_d;
  logic [3:0]        next_q, next_d;
  logic              seg_done_q, seg_done_d;

  logic       running, running_d;
  logic       tick, start_ok, abort, arrive, dwell_done, advance, last;
  logic [8:0] tgt_row, step_row;
  logic [9:0] tgt_col, step_col;
  logic [4:0] now5, nxt5;

  assign running   = (state_q == StHome) || (state_q == StMove) || (state_q == StDwell);
  assign running_d = (state_d == StHome) || (state_d == StMove) || (state_d == StDwell);
  assign tick      = running && (tick_cnt_q == TickLast);
  assign start_ok  = start_i && learn_mode_i && ((state_q == StIdle) || (state_q == StDone));
  assign abort     = !learn_mode_i && (state_q != StIdle);
  assign tgt_row   = node_row(next_q);
  assign tgt_col   = node_col(next_q);
  assign now5      = {1'b0, now_q};
  assign nxt5      = {1'b0, next_q};
  assign last      = (idx_q == spell_last(spell_q));

  // Adjacent nodes are approached STEP_PX at a time; anything else jumps straight there.
  always_comb begin
    step_row = tgt_row;
    step_col = tgt_col;
    if (nxt5 == now5 + 5'd1) begin
      step_row = row_q;
      step_col = col_q + StepCol;
    end else if (now5 == nxt5 + 5'd1) begin
      step_row = row_q;
      step_col = col_q - StepCol;
    end else if (nxt5 == now5 + 5'd4) begin
      step_row = row_q + StepRow;
      step_col = col_q;
    end else if (now5 == nxt5 + 5'd4) begin
      step_row = row_q - StepRow;
      step_col = col_q;
    end
  end

  assign arrive = (state_q == StMove) &&
                  (((row_q == tgt_row) && (col_q == tgt_col)) ||
                   (tick && (step_row == tgt_row) && (step_col == tgt_col)));
  assign dwell_done = (state_q == StDwell) && tick && (hold_cnt_q == HoldLast);
  assign advance    = dwell_done || ((HOLD_TICKS == 0) && arrive);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      spell_q     <= 2'd0;
      idx_q       <= 3'd0;
      tick_cnt_q  <= '0;
      frame_cnt_q <= '0;
      frame_sel_q <= 2'd0;
      hold_cnt_q  <= '0;
      row_q       <= 9'd190;
      col_q       <= 10'd270;
      now_q       <= 4'd5;
      next_q      <= 4'd5;
      seg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      spell_q     <= spell_d;
      idx_q       <= idx_d;
      tick_cnt_q  <= tick_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_sel_q <= frame_sel_d;
      hold_cnt_q  <= hold_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      now_q       <= now_d;
      next_q      <= next_d;
      seg_done_q  <= seg_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    spell_d    = spell_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    now_d      = now_q;
    next_d     = next_q;
    seg_done_d = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_d    = StHome;
            spell_d    = spell_sel_i;
            idx_d      = 3'd1;
            hold_cnt_d = '0;
            now_d      = spell_node(spell_sel_i, 3'd0);
            next_d     = spell_node(spell_sel_i, 3'd1);
            row_d      = node_row(spell_node(spell_sel_i, 3'd0));
            col_d      = node_col(spell_node(spell_sel_i, 3'd0));
          end
        end
        StHome: begin
          if (tick) state_d = StMove;
        end
        StMove: begin
          if (arrive) begin
            row_d      = tgt_row;
            col_d      = tgt_col;
            now_d      = next_q;
            seg_done_d = 1'b1;
            hold_cnt_d = '0;
            if (HOLD_TICKS > 0) state_d = StDwell;
          end else if (tick) begin
            row_d = step_row;
            col_d = step_col;
          end
        end
        StDwell: begin
          if (tick && (hold_cnt_q != HoldLast)) hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
        default: state_d = StIdle;
      endcase
      if (advance) begin
        if (last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          next_d  = spell_node(spell_q, idx_q + 3'd1);
          state_d = StMove;
        end
      end
    end
  end

  // Tick and frame counters only free-run across consecutive busy cycles.
  always_comb begin
    tick_cnt_d  = '0;
    frame_cnt_d = '0;
    frame_sel_d = 2'd0;
    if (running && running_d) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        frame_sel_d = (frame_sel_q == 2'd2) ? 2'd0 : frame_sel_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FrameW'(1);
        frame_sel_d = frame_sel_q;
      end
    end
  end

  always_comb begin
    wand_row_o  = row_q;
    wand_col_o  = col_q;
    now_node_o  = now_q;
    next_node_o = next_q;
    frame_sel_o = frame_sel_q;
    seg_done_o  = seg_done_q;
    busy_o      = running;
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_wand_path_controller.sv
// Bench for wand_path_controller: a geometric path model fills position/arrival queues that
// a negedge monitor drains as the wand moves.
module tb_wand_path_controller;

  localparam int StepT  = 4;
  localparam int FrameT = 3;
  localparam int StepPx = 20;
  localparam int HoldT  = 1;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       learn_mode_i = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] spell_sel_i = 2'd0;
  logic [8:0] wand_row_o;
  logic [9:0] wand_col_o;
  logic [3:0] now_node_o;
  logic [3:0] next_node_o;
  logic [1:0] frame_sel_o;
  logic       busy_o;
  logic       seg_done_o;
  logic       done_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int seg_cnt = 0;

  typedef struct {int row; int col; int gap;} pos_t;
  typedef struct {int node; int row; int col;} arr_t;
  pos_t pos_q[$];
  arr_t arr_q[$];
  pos_t mon_p;
  arr_t mon_a;

  int spells[4][8] = '{'{5, 6, 7, 11, 10, 0, 0, 0}, '{0, 1, 2, 3, 7, 11, 15, 0},
                       '{12, 8, 4, 0, 0, 0, 0, 0}, '{5, 6, 5, 6, 0, 0, 0, 0}};
  int lens[4] = '{5, 7, 4, 4};

  wand_path_controller #(
    .STEP_TICKS (StepT),
    .FRAME_TICKS(FrameT),
    .STEP_PX    (StepPx),
    .HOLD_TICKS (HoldT)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .learn_mode_i(learn_mode_i),
    .start_i     (start_i),
    .spell_sel_i (spell_sel_i),
    .wand_row_o  (wand_row_o),
    .wand_col_o  (wand_col_o),
    .now_node_o  (now_node_o),
    .next_node_o (next_node_o),
    .frame_sel_o (frame_sel_o),
    .busy_o      (busy_o),
    .seg_done_o  (seg_done_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected positions: every step of every segment, with the cycle gap since the last change.
  task automatic push_spell(input int s);
    int r, c, rb, cb, dr, dc, a, b, gap;
    for (int k = 1; k < lens[s]; k++) begin
      a  = spells[s][k-1];
      b  = spells[s][k];
      r  = 90 + 100 * (a / 4);
      c  = 170 + 100 * (a % 4);
      rb = 90 + 100 * (b / 4);
      cb = 170 + 100 * (b % 4);
      dr = (rb > r) ? 1 : ((rb < r) ? -1 : 0);
      dc = (cb > c) ? 1 : ((cb < c) ? -1 : 0);
      for (int j = 1; j <= 100 / StepPx; j++) begin
        r += dr * StepPx;
        c += dc * StepPx;
        if (j > 1) gap = StepT;
        else if (k == 1) gap = 2 * StepT;
        else gap = (HoldT + 1) * StepT;
        pos_q.push_back('{r, c, gap});
      end
      arr_q.push_back('{b, rb, cb});
    end
  endtask

  int  prev_row, prev_col, last_chg;
  bit  prev_busy = 1'b0;

  always @(negedge clk_i) begin
    if (busy_o && !prev_busy) begin
      prev_row = int'(wand_row_o);
      prev_col = int'(wand_col_o);
      last_chg = cyc;
    end else if (busy_o && (int'(wand_row_o) != prev_row || int'(wand_col_o) != prev_col)) begin
      total++;
      if (pos_q.size() == 0) begin
        bad++;
        $display("FAIL pos_extra: got %0d/%0d, required no move", wand_row_o, wand_col_o);
      end else begin
        mon_p = pos_q.pop_front();
        if (int'(wand_row_o) !== mon_p.row || int'(wand_col_o) !== mon_p.col) begin
          bad++;
          $display("FAIL pos_step: got %0d/%0d, required %0d/%0d", wand_row_o, wand_col_o,
                   mon_p.row, mon_p.col);
        end
        total++;
        if (cyc - last_chg !== mon_p.gap) begin
          bad++;
          $display("FAIL pos_gap: got %0d cycles, required %0d", cyc - last_chg, mon_p.gap);
        end
      end
      prev_row = int'(wand_row_o);
      prev_col = int'(wand_col_o);
      last_chg = cyc;
    end
    if (seg_done_o) begin
      seg_cnt++;
      total++;
      if (arr_q.size() == 0) begin
        bad++;
        $display("FAIL seg_extra: got pulse at node %0d, required none", now_node_o);
      end else begin
        mon_a = arr_q.pop_front();
        if (int'(now_node_o) !== mon_a.node || int'(wand_row_o) !== mon_a.row ||
            int'(wand_col_o) !== mon_a.col) begin
          bad++;
          $display("FAIL seg_arrive: got node %0d at %0d/%0d, required node %0d at %0d/%0d",
                   now_node_o, wand_row_o, wand_col_o, mon_a.node, mon_a.row, mon_a.col);
        end
      end
    end
    prev_busy = busy_o;
  end

  task automatic do_start(input logic [1:0] sel);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    spell_sel_i = sel;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    spell_sel_i = ~sel;
    @(negedge clk_i);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (wand_row_o !== 9'd190 || wand_col_o !== 10'd270) begin
      bad++;
      $display("FAIL reset_pos: got %0d/%0d, required 190/270", wand_row_o, wand_col_o);
    end
    total++;
    if (now_node_o !== 4'd5 || next_node_o !== 4'd5) begin
      bad++;
      $display("FAIL reset_nodes: got %0d/%0d, required 5/5", now_node_o, next_node_o);
    end
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || seg_done_o !== 1'b0 || frame_sel_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b done=%b seg=%b frame=%0d, required 0/0/0/0",
               busy_o, done_o, seg_done_o, frame_sel_o);
    end
  endtask

  task automatic test_spell3;
    int s0;
    bit ok;
    s0 = seg_cnt;
    learn_mode_i = 1'b1;
    push_spell(3);
    do_start(2'd3);
    total++;
    if (busy_o !== 1'b1 || done_o !== 1'b0 || wand_row_o !== 9'd190 || wand_col_o !== 10'd270 ||
        now_node_o !== 4'd5 || next_node_o !== 4'd6) begin
      bad++;
      $display("FAIL s3_home: got busy=%b done=%b %0d/%0d nodes %0d/%0d, required 1 0 190/270 5/6",
               busy_o, done_o, wand_row_o, wand_col_o, now_node_o, next_node_o);
    end
    wait_done(400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL s3_timeout: got done=%b, required 1", done_o);
    end
    total++;
    if (wand_row_o !== 9'd190 || wand_col_o !== 10'd370 || now_node_o !== 4'd6 ||
        busy_o !== 1'b0 || frame_sel_o !== 2'd0) begin
      bad++;
      $display("FAIL s3_final: got %0d/%0d node %0d busy=%b frame=%0d, required 190/370 6 0 0",
               wand_row_o, wand_col_o, now_node_o, busy_o, frame_sel_o);
    end
    total++;
    if (seg_cnt - s0 !== 3 || pos_q.size() != 0 || arr_q.size() != 0) begin
      bad++;
      $display("FAIL s3_segs: got %0d pulses, %0d/%0d left, required 3 and 0/0",
               seg_cnt - s0, pos_q.size(), arr_q.size());
    end
  endtask

  task automatic test_frame;
    int s0;
    bit ok;
    s0 = seg_cnt;
    push_spell(0);
    do_start(2'd0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (int'(frame_sel_o) !== (i / FrameT) % 3) begin
        bad++;
        $display("FAIL frame_seq[%0d]: got %0d, required %0d", i, frame_sel_o, (i / FrameT) % 3);
      end
      @(negedge clk_i);
    end
    wait_done(600, ok);
    total++;
    if (!ok || frame_sel_o !== 2'd0 || now_node_o !== 4'd10 || wand_row_o !== 9'd290 ||
        wand_col_o !== 10'd370 || seg_cnt - s0 !== 4) begin
      bad++;
      $display("FAIL s0_final: got done=%b frame=%0d node %0d %0d/%0d segs %0d, required 1 0 10 290/370 4",
               done_o, frame_sel_o, now_node_o, wand_row_o, wand_col_o, seg_cnt - s0);
    end
  endtask

  task automatic test_spell1;
    int s0;
    bit ok;
    s0 = seg_cnt;
    push_spell(1);
    do_start(2'd1);
    total++;
    if (wand_row_o !== 9'd90 || wand_col_o !== 10'd170 || now_node_o !== 4'd0 ||
        next_node_o !== 4'd1) begin
      bad++;
      $display("FAIL s1_home: got %0d/%0d nodes %0d/%0d, required 90/170 0/1",
               wand_row_o, wand_col_o, now_node_o, next_node_o);
    end
    wait_done(1000, ok);
    total++;
    if (!ok || now_node_o !== 4'd15 || wand_row_o !== 9'd390 || wand_col_o !== 10'd470 ||
        seg_cnt - s0 !== 6 || pos_q.size() != 0) begin
      bad++;
      $display("FAIL s1_final: got done=%b node %0d %0d/%0d segs %0d, required 1 15 390/470 6",
               done_o, now_node_o, wand_row_o, wand_col_o, seg_cnt - s0);
    end
  endtask

  task automatic test_abort;
    int s0;
    bit ok;
    push_spell(2);
    do_start(2'd2);
    total++;
    if (wand_row_o !== 9'd390 || wand_col_o !== 10'd170 || now_node_o !== 4'd12 ||
        next_node_o !== 4'd8) begin
      bad++;
      $display("FAIL s2_home: got %0d/%0d nodes %0d/%0d, required 390/170 12/8",
               wand_row_o, wand_col_o, now_node_o, next_node_o);
    end
    s0 = seg_cnt;
    repeat (14) @(posedge clk_i);
    #1 learn_mode_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wand_row_o !== 9'd350 || wand_col_o !== 10'd170 ||
        now_node_o !== 4'd12 || next_node_o !== 4'd8 || frame_sel_o !== 2'd0) begin
      bad++;
      $display("FAIL abort_state: got busy=%b done=%b %0d/%0d nodes %0d/%0d frame %0d, required 0 0 350/170 12/8 0",
               busy_o, done_o, wand_row_o, wand_col_o, now_node_o, next_node_o, frame_sel_o);
    end
    pos_q.delete();
    arr_q.delete();
    repeat (6) @(negedge clk_i);
    total++;
    if (wand_row_o !== 9'd350 || busy_o !== 1'b0 || seg_cnt != s0) begin
      bad++;
      $display("FAIL abort_hold: got row %0d busy=%b segs %0d, required 350 0 0",
               wand_row_o, busy_o, seg_cnt - s0);
    end
    @(posedge clk_i);
    #1 learn_mode_i = 1'b1;
    push_spell(2);
    do_start(2'd2);
    total++;
    if (busy_o !== 1'b1 || wand_row_o !== 9'd390 || wand_col_o !== 10'd170 ||
        now_node_o !== 4'd12 || next_node_o !== 4'd8) begin
      bad++;
      $display("FAIL restart_home: got busy=%b %0d/%0d nodes %0d/%0d, required 1 390/170 12/8",
               busy_o, wand_row_o, wand_col_o, now_node_o, next_node_o);
    end
    wait_done(600, ok);
    total++;
    if (!ok || now_node_o !== 4'd0 || wand_row_o !== 9'd90 || wand_col_o !== 10'd170 ||
        seg_cnt - s0 !== 3) begin
      bad++;
      $display("FAIL s2_final: got done=%b node %0d %0d/%0d segs %0d, required 1 0 90/170 3",
               done_o, now_node_o, wand_row_o, wand_col_o, seg_cnt - s0);
    end
  endtask

  task automatic test_ignored_start;
    int s0;
    bit ok;
    @(posedge clk_i); #1 reset_i = 1'b1;
    @(posedge clk_i); #1 reset_i = 1'b0;
    learn_mode_i = 1'b0;
    start_i = 1'b1;
    spell_sel_i = 2'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    learn_mode_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wand_row_o !== 9'd190 || wand_col_o !== 10'd270 ||
        now_node_o !== 4'd5 || next_node_o !== 4'd5) begin
      bad++;
      $display("FAIL nolearn_start: got busy=%b done=%b %0d/%0d nodes %0d/%0d, required 0 0 190/270 5/5",
               busy_o, done_o, wand_row_o, wand_col_o, now_node_o, next_node_o);
    end
    s0 = seg_cnt;
    push_spell(3);
    do_start(2'd3);
    repeat (10) @(posedge clk_i);
    #1 start_i = 1'b1;
    spell_sel_i = 2'd1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(400, ok);
    total++;
    if (!ok || now_node_o !== 4'd6 || wand_col_o !== 10'd370 || seg_cnt - s0 !== 3 ||
        pos_q.size() != 0 || arr_q.size() != 0) begin
      bad++;
      $display("FAIL busy_start: got done=%b node %0d col %0d segs %0d, required 1 6 370 3",
               done_o, now_node_o, wand_col_o, seg_cnt - s0);
    end
    do_start(2'd1);
    repeat (3) @(posedge clk_i);
    #1 start_i = 1'b1;
    learn_mode_i = 1'b0;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    learn_mode_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wand_row_o !== 9'd90 || wand_col_o !== 10'd170 ||
        now_node_o !== 4'd0 || next_node_o !== 4'd1) begin
      bad++;
      $display("FAIL abort_wins: got busy=%b done=%b %0d/%0d nodes %0d/%0d, required 0 0 90/170 0/1",
               busy_o, done_o, wand_row_o, wand_col_o, now_node_o, next_node_o);
    end
  endtask

  task automatic test_reset_mid_run;
    int s0;
    s0 = seg_cnt;
    push_spell(1);
    do_start(2'd1);
    repeat (20) @(posedge clk_i);
    #1 reset_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || wand_row_o !== 9'd190 || wand_col_o !== 10'd270 ||
        now_node_o !== 4'd5 || next_node_o !== 4'd5 || frame_sel_o !== 2'd0) begin
      bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b %0d/%0d nodes %0d/%0d frame %0d, required 0 0 190/270 5/5 0",
               busy_o, done_o, wand_row_o, wand_col_o, now_node_o, next_node_o, frame_sel_o);
    end
    total++;
    if (seg_cnt != s0 || pos_q.size() != 5 * 6 - 4) begin
      bad++;
      $display("FAIL midrun_progress: got segs %0d steps left %0d, required 0 and 26",
               seg_cnt - s0, pos_q.size());
    end
    pos_q.delete();
    arr_q.delete();
  endtask

  initial begin
    test_reset();
    test_spell3();
    test_frame();
    test_spell1();
    test_abort();
    test_ignored_start();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "bench timeout");
  end

endmodule
